lcd_nibble_rx: RTL and testbench

HD44780-style 4-bit LCD interface receiver: the panel end of the `LCD_EN`/`LCD_RS`/`DATA[7:4]` link driven by the calculator's LCD writer. It synchronises the strobe lines, reassembles nibble pairs into bytes, and executes the core command subset against an internal display RAM. It serves as a synthesizable loopback/display model for on-board self-test and as the golden responder in writer-side benches.

---
 rtl/lcd_nibble_rx_if.sv | 9 +
 rtl/lcd_nibble_rx.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_nibble_rx.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_nibble_rx_if.sv
// rtl/lcd_nibble_rx_if.sv - LCD_EN/LCD_RS/DATA[7:4] link between the LCD writer and the panel receiver
interface lcd_nibble_rx_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic [3:0] lcd_data;

  modport master (output lcd_en, output lcd_rs, output lcd_data);
  modport slave  (input  lcd_en, input  lcd_rs, input  lcd_data);
endinterface

// File: rtl/lcd_nibble_rx.sv
// rtl/lcd_nibble_rx.sv - HD44780-style 4-bit LCD receiver with command subset and display RAM
module lcd_nibble_rx #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  lcd_nibble_rx_if.slave lcd,
  output logic          byte_valid,
  output logic [7:0]    byte_out,
  output logic          byte_rs,
  output logic          four_bit,
  output logic          busy,
  output logic          overrun,
  output logic [AW-1:0] cursor,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        state, state_next;
  logic          en_s1, en_s, en_d;
  logic          rs_s1, rs_s;
  logic [3:0]    data_s1, data_s;
  logic [3:0]    nib_hold;
  logic          rs_hold;
  logic [3:0]    hi_nib;
  logic          phase_lo;
  logic          id;
  logic          clr_req;
  logic [AW-1:0] clr_idx;
  logic          clr_last;
  logic [7:0]    mem [DEPTH];

  logic          fall;
  logic          complete;
  logic [7:0]    cmp_byte;
  logic          exec;
  logic          wr_data;
  logic          cmd_clear;
  logic          cmd_home;
  logic          cmd_entry;
  logic          cmd_addr;
  logic          cmd_func;

  // Two-flop synchronisers for the strobe and bus, plus a delayed EN for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      en_s1   <= 1'b0;
      en_s    <= 1'b0;
      en_d    <= 1'b0;
      rs_s1   <= 1'b0;
      rs_s    <= 1'b0;
      data_s1 <= 4'h0;
      data_s  <= 4'h0;
    end else begin
      en_s1   <= lcd.lcd_en;
      en_s    <= en_s1;
      en_d    <= en_s;
      rs_s1   <= lcd.lcd_rs;
      rs_s    <= rs_s1;
      data_s1 <= lcd.lcd_data;
      data_s  <= data_s1;
    end
  end

  assign fall = en_d & ~en_s;

  // Track the bus while EN is high so the values just before the fall are kept
  always_ff @(posedge clk) begin
    if (rst) begin
      nib_hold <= 4'h0;
      rs_hold  <= 1'b0;
    end else if (en_s) begin
      nib_hold <= data_s;
      rs_hold  <= rs_s;
    end
  end

  // Byte assembly and command decode; commands only execute while running
  always_comb begin
    complete  = 1'b0;
    cmp_byte  = 8'h00;
    if (fall) begin
      if (!four_bit) begin
        complete = 1'b1;
        cmp_byte = {nib_hold, 4'h0};
      end else if (phase_lo) begin
        complete = 1'b1;
        cmp_byte = {hi_nib, nib_hold};
      end
    end
    exec      = complete && (state == S_RUN);
    wr_data   = exec && rs_hold;
    cmd_clear = exec && !rs_hold && (cmp_byte == 8'h01);
    cmd_home  = exec && !rs_hold && (cmp_byte[7:1] == 7'h01);
    cmd_entry = exec && !rs_hold && (cmp_byte[7:2] == 6'h01);
    cmd_addr  = exec && !rs_hold && cmp_byte[7];
    cmd_func  = exec && !rs_hold && !four_bit && (cmp_byte[7:4] == 4'h2);
  end

  // Interface width and nibble phase; a function-set in 8-bit mode realigns to the high nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      four_bit <= 1'b0;
      phase_lo <= 1'b0;
      hi_nib   <= 4'h0;
    end else begin
      if (fall && four_bit) begin
        if (!phase_lo) begin
          hi_nib   <= nib_hold;
          phase_lo <= 1'b1;
        end else begin
          phase_lo <= 1'b0;
        end
      end
      if (cmd_func) begin
        four_bit <= 1'b1;
        phase_lo <= 1'b0;
      end
    end
  end

  // Completed-byte outputs; overrun flags a byte that lands while clearing
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
      byte_rs    <= 1'b0;
      overrun    <= 1'b0;
      clr_req    <= 1'b0;
    end else begin
      byte_valid <= complete;
      overrun    <= complete && (state == S_CLEAR);
      clr_req    <= cmd_clear;
      if (complete) begin
        byte_out <= cmp_byte;
        byte_rs  <= rs_hold;
      end
    end
  end

  assign clr_last = (clr_idx == AW'(DEPTH - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_next;
  end

  // FSM next-state: clear sweeps the whole RAM once, then returns to normal operation
  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (clr_last) state_next = S_RUN;
      S_RUN:   if (clr_req)  state_next = S_CLEAR;
      default: state_next = S_CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == S_CLEAR);
  end

  // Clear index restarts from 0 every time CLEAR is entered
  always_ff @(posedge clk) begin
    if (rst || state != S_CLEAR) clr_idx <= '0;
    else                         clr_idx <= clr_idx + AW'(1);
  end

  // Address counter and increment/decrement direction
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor <= '0;
      id     <= 1'b1;
    end else if (state == S_CLEAR && clr_last) begin
      cursor <= '0;
      id     <= 1'b1;
    end else if (wr_data) begin
      cursor <= id ? cursor + AW'(1) : cursor - AW'(1);
    end else if (cmd_home) begin
      cursor <= '0;
    end else if (cmd_entry) begin
      id <= cmp_byte[1];
    end else if (cmd_addr) begin
      cursor <= cmp_byte[AW-1:0];
    end
  end

  // Display RAM write port: clear pattern has priority, data writes only while running
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)  mem[clr_idx] <= 8'h20;
    else if (wr_data)      mem[cursor]  <= cmp_byte;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// tb/tb_lcd_nibble_rx.sv - randomized self-checking bench for lcd_nibble_rx
module tb_lcd_nibble_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid, byte_rs, four_bit, busy, overrun;
  logic [7:0] byte_out, rd_data;
  logic [3:0] cursor, rd_addr;

  always #5 clk = ~clk;

  lcd_nibble_rx_if lcd_if ();

  lcd_nibble_rx #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .lcd(lcd_if.slave),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs),
    .four_bit(four_bit), .busy(busy), .overrun(overrun), .cursor(cursor),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct {int t; logic [7:0] b; logic rs; logic ov;} ev_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int busy_start = -1000;
  bit chk_en = 0;
  ev_t q[$];
  ev_t cev;
  bit  bz;

  logic [7:0] mem_m [16];
  logic [3:0] cur_m;
  logic       id_m, four_m, ph_m;
  logic [3:0] hi_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit busy_at(input int x);
    return (x >= busy_start) && (x < busy_start + 16);
  endfunction

  // Per-cycle comparison of the byte stream, overrun and busy against the model
  always @(negedge clk) begin
    if (overrun) ov_cnt++;
    if (chk_en) begin
      bz = busy_at(cyc);
      chk("busy", busy, bz);
      while (q.size() > 0 && q[0].t < cyc) begin
        cev = q.pop_front();
        errors++;
        $display("FAIL byte_event_missed: expected byte %0h at cycle %0d, now %0d", cev.b, cev.t, cyc);
      end
      if (q.size() > 0 && q[0].t == cyc) begin
        cev = q.pop_front();
        chk("byte_valid", byte_valid, 1'b1);
        chk("byte_out", byte_out, cev.b);
        chk("byte_rs", byte_rs, cev.rs);
        chk("overrun", overrun, cev.ov);
      end else begin
        chk("byte_valid_idle", byte_valid, 1'b0);
        chk("overrun_idle", overrun, 1'b0);
      end
    end
  end

  // Behavioural model of one completed byte landing in cycle t
  task automatic model_byte(input logic [7:0] b, input logic rs, input int t);
    logic ov;
    ov = busy_at(t - 1);
    q.push_back('{t, b, rs, ov});
    if (!ov) begin
      if (rs) begin
        mem_m[cur_m] = b;
        cur_m = id_m ? cur_m + 4'd1 : cur_m - 4'd1;
      end else if (b == 8'h01) begin
        busy_start = t + 1;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h20;
        cur_m = 4'd0;
        id_m  = 1'b1;
      end else if (b == 8'h02 || b == 8'h03) begin
        cur_m = 4'd0;
      end else if (b >= 8'h04 && b <= 8'h07) begin
        id_m = b[1];
      end else if (b >= 8'h80) begin
        cur_m = b[3:0];
      end else if (!four_m && b[7:4] == 4'h2) begin
        four_m = 1'b1;
        ph_m   = 1'b0;
      end
    end
  endtask

  // One EN strobe: high for hw cycles, low for lw cycles, bus stable throughout
  task automatic nib(input logic rs, input logic [3:0] n, input int hw, input int lw);
    int t;
    lcd_if.lcd_rs   = rs;
    lcd_if.lcd_data = n;
    lcd_if.lcd_en   = 1'b1;
    repeat (hw) @(posedge clk);
    #1;
    lcd_if.lcd_en = 1'b0;
    t = cyc + 3;
    if (!four_m) begin
      model_byte({n, 4'h0}, rs, t);
    end else if (!ph_m) begin
      hi_m = n;
      ph_m = 1'b1;
    end else begin
      ph_m = 1'b0;
      model_byte({hi_m, n}, rs, t);
    end
    repeat (lw) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b, input int hw, input int lw);
    if (four_m) begin
      nib(rs, b[7:4], hw, lw);
      nib(rs, b[3:0], hw, lw);
    end else begin
      nib(rs, b[7:4], hw, lw);
    end
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst = 1'b1;
    lcd_if.lcd_en = 1'b0;
    lcd_if.lcd_rs = 1'b0;
    lcd_if.lcd_data = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_byte_rs", byte_rs, 1'b0);
    chk("rst_four_bit", four_bit, 1'b0);
    chk("rst_cursor", cursor, 4'd0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_busy", busy, 1'b1);
    rst = 1'b0;
    busy_start = cyc;
    q.delete();
    four_m = 1'b0;
    ph_m   = 1'b0;
    cur_m  = 4'd0;
    id_m   = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h20;
    chk_en = 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || cyc < busy_start + 18) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL wait_idle: timed out with %0d bytes outstanding", q.size());
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    rd_addr = a;
    @(posedge clk);
    #1;
    v = rd_data;
  endtask

  task automatic check_state();
    logic [7:0] v;
    chk("cursor", cursor, cur_m);
    chk("four_bit", four_bit, four_m);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      chk($sformatf("mem[%0d]", i), v, mem_m[i]);
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic [7:0] cmds [8];
    int ov0;
    cmds = '{8'h01, 8'h02, 8'h04, 8'h06, 8'h80, 8'h30, 8'h20, 8'h10};
    rd_addr = 4'd0;
    lcd_if.lcd_en = 1'b0;
    lcd_if.lcd_rs = 1'b0;
    lcd_if.lcd_data = 4'h0;

    // Reset clear
    do_reset();
    wait_idle();
    check_state();
    rd(4'd9, v);
    chk("clear_lit", v, 8'h20);

    // Mode switch and first data write
    nib(1'b0, 4'h2, 3, 3);
    send_byte(1'b1, 8'h41, 3, 3);
    wait_idle();
    chk("mode_four_bit_lit", four_bit, 1'b1);
    chk("mode_byte_out_lit", byte_out, 8'h41);
    chk("mode_byte_rs_lit", byte_rs, 1'b1);
    chk("mode_cursor_lit", cursor, 4'd1);
    rd(4'd0, v);
    chk("mode_mem0_lit", v, 8'h41);
    check_state();

    // Addressing and decrement entry mode
    send_byte(1'b0, 8'h8F, 3, 3);
    send_byte(1'b0, 8'h04, 3, 3);
    send_byte(1'b1, 8'h31, 3, 3);
    send_byte(1'b1, 8'h32, 3, 3);
    wait_idle();
    rd(4'd15, v);
    chk("addr_mem15_lit", v, 8'h31);
    rd(4'd14, v);
    chk("addr_mem14_lit", v, 8'h32);
    chk("addr_cursor_lit", cursor, 4'd13);

    // Increment across the top wrap, then decrement across the bottom wrap
    send_byte(1'b0, 8'h06, 3, 3);
    send_byte(1'b0, 8'h8E, 3, 3);
    send_byte(1'b1, 8'h61, 3, 3);
    send_byte(1'b1, 8'h62, 3, 3);
    wait_idle();
    chk("wrap_up_cursor_lit", cursor, 4'd0);
    rd(4'd15, v);
    chk("wrap_up_mem15_lit", v, 8'h62);
    send_byte(1'b0, 8'h04, 3, 3);
    send_byte(1'b1, 8'h63, 3, 3);
    wait_idle();
    chk("wrap_down_cursor_lit", cursor, 4'd15);
    send_byte(1'b0, 8'h06, 3, 3);
    wait_idle();
    check_state();

    // Minimum widths, then the writer's long pulses
    for (int i = 0; i < 10; i++) send_byte(1'b1, 8'h30 + 8'(i), 3, 3);
    for (int i = 0; i < 10; i++) send_byte(1'b1, 8'h41 + 8'(i), 21, 3);
    wait_idle();
    check_state();

    // Overrun: data byte arrives during the clear
    ov0 = ov_cnt;
    send_byte(1'b0, 8'h01, 3, 3);
    send_byte(1'b1, 8'h55, 3, 3);
    wait_idle();
    chk("overrun_count_lit", ov_cnt - ov0, 1);
    rd(4'd0, v);
    chk("overrun_mem0_lit", v, 8'h20);
    check_state();

    // Reset with a pending high nibble
    nib(1'b1, 4'h4, 3, 3);
    do_reset();
    wait_idle();
    check_state();
    nib(1'b0, 4'h2, 3, 3);
    send_byte(1'b1, 8'h5A, 3, 3);
    wait_idle();
    chk("rstmid_byte_out_lit", byte_out, 8'h5A);
    rd(4'd0, v);
    chk("rstmid_mem0_lit", v, 8'h5A);
    check_state();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int hw, lw;
      hw = 3 + int'($urandom_range(0, 5));
      lw = 3 + int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        send_byte(1'b1, 8'($urandom), hw, lw);
      end else begin
        v = cmds[$urandom_range(0, 7)];
        if (v == 8'h80) v = 8'h80 | 8'($urandom_range(0, 127));
        if (v == 8'h01 && $urandom_range(0, 3) != 0) v = 8'h02;
        send_byte(1'b0, v, hw, lw);
      end
    end
    wait_idle();
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
